// File: rtl/pong_game_core.sv
// Frame-rate game engine for pong: ball/paddle motion, collisions, BCD scoring
// and the serve/play/point/game-over state machine. Everything steps on frame_tick.
module pong_game_core #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V       = 2,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 4,
  parameter int PADDLE_V     = 4,
  parameter int LP_X         = 16,
  parameter int RP_X         = 620,
  parameter int SERVE_FRAMES = 30,
  parameter int WIN_SCORE    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic        ai_mode,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [9:0]  pad1_y,
  output logic [9:0]  pad2_y,
  output logic [15:0] score,
  output logic [2:0]  state,
  output logic [1:0]  winner,
  output logic        point_pulse
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam logic signed [10:0] HA       = 11'(H_ACTIVE);
  localparam logic signed [10:0] VA       = 11'(V_ACTIVE);
  localparam logic signed [10:0] BS       = 11'(BALL_SIZE);
  localparam logic signed [10:0] BV       = 11'(BALL_V);
  localparam logic signed [10:0] PH       = 11'(PADDLE_H);
  localparam logic signed [10:0] PV       = 11'(PADDLE_V);
  localparam logic signed [10:0] LP_FACE  = 11'(LP_X + PADDLE_W);
  localparam logic signed [10:0] RP_FACE  = 11'(RP_X);
  localparam logic signed [10:0] PAD_MAX  = 11'(V_ACTIVE - PADDLE_H);
  localparam logic signed [10:0] BALL_X0  = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [10:0] BALL_Y0  = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [10:0] PAD_Y0   = 11'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic signed [10:0] HALF_B   = 11'(BALL_SIZE / 2);
  localparam logic signed [10:0] HALF_P   = 11'(PADDLE_H / 2);
  localparam int                 CW       = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0]      SERVE_LAST = CW'(SERVE_FRAMES - 1);
  localparam logic [7:0]         WIN_BCD  = 8'(((WIN_SCORE / 10) * 16) + (WIN_SCORE % 10));

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic signed [10:0] pad_step(input logic signed [10:0] y,
                                                  input logic up, input logic dn);
    logic signed [10:0] r;
    if (up && !dn) begin
      if (y < PV) r = 11'sd0;
      else        r = y - PV;
    end else if (dn && !up) begin
      if (y > PAD_MAX - PV) r = PAD_MAX;
      else                  r = y + PV;
    end else begin
      r = y;
    end
    return r;
  endfunction

  function automatic logic overlap(input logic signed [10:0] by, input logic signed [10:0] py);
    return (by + BS > py) && (by < py + PH);
  endfunction

  // Saturate to the unsigned output range; negatives never reach a port.
  function automatic logic [9:0] to_u10(input logic signed [10:0] v);
    logic [9:0] r;
    if (v[10]) r = 10'd0;
    else       r = v[9:0];
    return r;
  endfunction

  state_t             state_r, state_nx_s;
  logic [9:0]         ball_x_r, ball_y_r, pad1_r, pad2_r;
  logic               dir_x_r, dir_y_r, dir_x_nx_s, dir_y_nx_s;
  logic [15:0]        score_r, score_nx_s;
  logic [1:0]         winner_r, winner_nx_s;
  logic               pulse_r, pulse_nx_s;
  logic               scorer_r, scorer_nx_s;
  logic [CW-1:0]      serve_cnt_r, serve_cnt_nx_s;
  logic signed [10:0] bx_s, by_s, p1_s, p2_s;
  logic signed [10:0] bx_nx_s, by_nx_s, p1_nx_s, p2_nx_s;
  logic signed [10:0] p1_mv_s, p2_mv_s;
  logic               ai_up_s, ai_dn_s, p2_up_s, p2_dn_s;

  assign bx_s = $signed({1'b0, ball_x_r});
  assign by_s = $signed({1'b0, ball_y_r});
  assign p1_s = $signed({1'b0, pad1_r});
  assign p2_s = $signed({1'b0, pad2_r});

  // Automatic right paddle chases the ball centre with a PADDLE_V dead band.
  assign ai_up_s = (by_s + HALF_B) < (p2_s + HALF_P - PV);
  assign ai_dn_s = (by_s + HALF_B) > (p2_s + HALF_P + PV);
  assign p2_up_s = ai_mode ? ai_up_s : p2_up;
  assign p2_dn_s = ai_mode ? ai_dn_s : p2_down;
  assign p1_mv_s = pad_step(p1_s, p1_up, p1_down);
  assign p2_mv_s = pad_step(p2_s, p2_up_s, p2_dn_s);

  // Next-state and next-datapath logic, evaluated once per frame tick
  always_comb begin
    state_nx_s     = state_r;
    bx_nx_s        = bx_s;
    by_nx_s        = by_s;
    p1_nx_s        = p1_s;
    p2_nx_s        = p2_s;
    dir_x_nx_s     = dir_x_r;
    dir_y_nx_s     = dir_y_r;
    score_nx_s     = score_r;
    winner_nx_s    = winner_r;
    pulse_nx_s     = 1'b0;
    scorer_nx_s    = scorer_r;
    serve_cnt_nx_s = serve_cnt_r;
    if (frame_tick) begin
      case (state_r)
        ST_IDLE, ST_GAMEOVER: begin
          if (start) begin
            state_nx_s     = ST_SERVE;
            serve_cnt_nx_s = '0;
            bx_nx_s        = BALL_X0;
            by_nx_s        = BALL_Y0;
            score_nx_s     = 16'h0000;
            winner_nx_s    = 2'b00;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_SERVE: begin
          p1_nx_s = p1_mv_s;
          p2_nx_s = p2_mv_s;
          if (serve_cnt_r == SERVE_LAST) state_nx_s = ST_PLAY;
          else                           serve_cnt_nx_s = serve_cnt_r + CW'(1);
        end
        ST_PLAY: begin
          p1_nx_s = p1_mv_s;
          p2_nx_s = p2_mv_s;
          if (!dir_y_r && (by_s < BV)) begin
            by_nx_s    = 11'sd0;
            dir_y_nx_s = 1'b1;
          end else if (dir_y_r && (by_s + BS + BV > VA)) begin
            by_nx_s    = VA - BS;
            dir_y_nx_s = 1'b0;
          end else if (dir_y_r) begin
            by_nx_s = by_s + BV;
          end else begin
            by_nx_s = by_s - BV;
          end
          // Paddle faces are tested before the misses behind them.
          if (!dir_x_r && (bx_s >= LP_FACE) && (bx_s - BV < LP_FACE) && overlap(by_s, p1_mv_s)) begin
            bx_nx_s    = LP_FACE;
            dir_x_nx_s = 1'b1;
          end else if (!dir_x_r && (bx_s < BV)) begin
            bx_nx_s          = 11'sd0;
            score_nx_s[15:8] = bcd_inc(score_r[15:8]);
            scorer_nx_s      = 1'b1;
            dir_x_nx_s       = 1'b1;
            pulse_nx_s       = 1'b1;
            state_nx_s       = ST_POINT;
          end else if (dir_x_r && (bx_s + BS <= RP_FACE) && (bx_s + BS + BV > RP_FACE) && overlap(by_s, p2_mv_s)) begin
            bx_nx_s    = RP_FACE - BS;
            dir_x_nx_s = 1'b0;
          end else if (dir_x_r && (bx_s + BS + BV >= HA)) begin
            bx_nx_s         = HA - BS;
            score_nx_s[7:0] = bcd_inc(score_r[7:0]);
            scorer_nx_s     = 1'b0;
            dir_x_nx_s      = 1'b0;
            pulse_nx_s      = 1'b1;
            state_nx_s      = ST_POINT;
          end else if (dir_x_r) begin
            bx_nx_s = bx_s + BV;
          end else begin
            bx_nx_s = bx_s - BV;
          end
        end
        ST_POINT: begin
          p1_nx_s = p1_mv_s;
          p2_nx_s = p2_mv_s;
          if (!scorer_r && (score_r[7:0] == WIN_BCD)) begin
            state_nx_s  = ST_GAMEOVER;
            winner_nx_s = 2'b01;
          end else if (scorer_r && (score_r[15:8] == WIN_BCD)) begin
            state_nx_s  = ST_GAMEOVER;
            winner_nx_s = 2'b10;
          end else begin
            state_nx_s     = ST_SERVE;
            serve_cnt_nx_s = '0;
            bx_nx_s        = BALL_X0;
            by_nx_s        = BALL_Y0;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // State and datapath registers; every output comes straight from here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ball_x_r    <= to_u10(BALL_X0);
      ball_y_r    <= to_u10(BALL_Y0);
      pad1_r      <= to_u10(PAD_Y0);
      pad2_r      <= to_u10(PAD_Y0);
      dir_x_r     <= 1'b1;
      dir_y_r     <= 1'b1;
      score_r     <= 16'h0000;
      winner_r    <= 2'b00;
      pulse_r     <= 1'b0;
      scorer_r    <= 1'b0;
      serve_cnt_r <= '0;
    end else begin
      state_r     <= state_nx_s;
      ball_x_r    <= to_u10(bx_nx_s);
      ball_y_r    <= to_u10(by_nx_s);
      pad1_r      <= to_u10(p1_nx_s);
      pad2_r      <= to_u10(p2_nx_s);
      dir_x_r     <= dir_x_nx_s;
      dir_y_r     <= dir_y_nx_s;
      score_r     <= score_nx_s;
      winner_r    <= winner_nx_s;
      pulse_r     <= pulse_nx_s;
      scorer_r    <= scorer_nx_s;
      serve_cnt_r <= serve_cnt_nx_s;
    end
  end

  assign ball_x      = ball_x_r;
  assign ball_y      = ball_y_r;
  assign pad1_y      = pad1_r;
  assign pad2_y      = pad2_r;
  assign score       = score_r;
  assign state       = state_r;
  assign winner      = winner_r;
  assign point_pulse = pulse_r;

endmodule
